input_vc_router: RTL

Router input stage, directly upstream of the per-port output modules; one instance per router port. It accepts flits from the link into per-VC FIFOs and computes an XY route on each head flit. It locks that route per VC until the tail flit, then presents one flit per cycle to one of the 4 other-port output modules. VC selection follows the same fixed priority the output stage uses.

---
 rtl/ravenoc_pkg.sv | 94 +++++++++
 rtl/input_vc_router_fifo.sv | 63 ++++++
 rtl/input_vc_router.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ravenoc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ravenoc_pkg
// Description : Shared NoC types, flit layout, and the XY routing helpers
//               used by the router input stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ravenoc_pkg;

    // Virtual channels
    localparam int NumVirtChn  = 2;
    localparam int VcWidth     = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;

    // Mesh coordinates
    localparam int XWidth      = 2;
    localparam int YWidth      = 2;

    // Flit layout: {type, payload}; head payload starts with {x, y, pkt_size}
    localparam int PktWidth      = 8;
    localparam int FlitTpWidth   = 2;
    localparam int FlitDataWidth = 32;
    localparam int FlitWidth     = FlitTpWidth + FlitDataWidth;
    localparam int HdrWidth      = FlitTpWidth + XWidth + YWidth + PktWidth;

    // Default per-VC buffering
    localparam int BufferDepth = 4;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } s_flit_type_t;

    // Which end of the VC index range wins arbitration
    typedef enum logic {
        ZeroHighPrior = 1'b0,
        ZeroLowPrior  = 1'b1
    } s_vc_prior_t;

    localparam s_vc_prior_t HighPriority = ZeroLowPrior;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } s_route_dir_t;

    typedef struct packed {
        logic [FlitWidth-1:0] fdata;
        logic                 valid;
        logic [VcWidth-1:0]   vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

    // Upper bits of a head flit
    typedef struct packed {
        logic [FlitTpWidth-1:0] ftype;
        logic [XWidth-1:0]      x_dest;
        logic [YWidth-1:0]      y_dest;
        logic [PktWidth-1:0]    pkt_size;
    } s_head_hdr_t;

    // Dimension-ordered routing: resolve X first, then Y
    function automatic s_route_dir_t xy_route(
        input logic [XWidth-1:0] x_dest,
        input logic [YWidth-1:0] y_dest,
        input logic [XWidth-1:0] x_id,
        input logic [YWidth-1:0] y_id
    );
        s_route_dir_t dir;
        if (x_dest > x_id)      dir = EAST;
        else if (x_dest < x_id) dir = WEST;
        else if (y_dest > y_id) dir = SOUTH;
        else if (y_dest < y_id) dir = NORTH;
        else                    dir = LOCAL;
        return dir;
    endfunction

    // Map a 5-way direction onto the 4 output modules, skipping our own port
    function automatic logic [1:0] compact_dir(
        input s_route_dir_t dir,
        input logic [2:0]   in_dir
    );
        return (3'(dir) < in_dir) ? 2'(dir) : 2'(3'(dir) - 3'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_vc_router_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vc_fifo
// Description : Registered single-clock FIFO holding the flits of one VC.
//               Output is the stored front entry; no write-through bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rptr];

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_vc_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : input_vc_router
// Description : Router input port. Buffers link flits per VC, XY-routes
//               each head, holds the route until the tail and presents one
//               flit per cycle to one of the four other-port output modules.
// Revision    : 1.0 - initial release
// ============================================================================
module input_vc_router
    import ravenoc_pkg::*;
#(
    parameter logic [XWidth-1:0] ROUTER_X_ID  = '0,
    parameter logic [YWidth-1:0] ROUTER_Y_ID  = '0,
    parameter int                INPUT_DIR    = 0,
    parameter int                BUFFER_DEPTH = BufferDepth
) (
    input  logic               clk,
    input  logic               arst,
    input  s_flit_req_t        fin_req_i,
    output s_flit_resp_t       fin_resp_o,
    output s_flit_req_t  [3:0] fout_req_o,
    input  s_flit_resp_t [3:0] fout_resp_i,
    output logic               err_o
);

    localparam logic [2:0] c_IN_DIR = 3'(INPUT_DIR);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_BUSY   = 1'b1;

    logic [NumVirtChn-1:0] w_push;
    logic [NumVirtChn-1:0] w_pop;
    logic [NumVirtChn-1:0] w_full;
    logic [NumVirtChn-1:0] w_empty;
    logic [FlitWidth-1:0]  w_front [NumVirtChn];

    logic [0:0]            r_state [NumVirtChn];
    s_route_dir_t          r_route [NumVirtChn];

    logic                  w_sel_valid;
    logic [VcWidth-1:0]    w_sel_vc;
    logic [FlitWidth-1:0]  w_front_flit;
    s_head_hdr_t           w_hdr;
    s_route_dir_t          w_head_route;
    logic                  w_drop;
    logic                  w_req_valid;
    s_route_dir_t          w_req_dir;
    logic [1:0]            w_out_idx;
    logic                  w_pop_any;

    // Ready depends only on the addressed VC's fullness, never on a pop
    assign fin_resp_o.ready = ~w_full[fin_req_i.vc_id];

    generate
        for (genvar v = 0; v < NumVirtChn; v++) begin : g_vc
            assign w_push[v] = fin_req_i.valid && fin_resp_o.ready &&
                               (fin_req_i.vc_id == VcWidth'(v));
            assign w_pop[v]  = w_pop_any && (w_sel_vc == VcWidth'(v));

            vc_fifo #(
                .DEPTH (BUFFER_DEPTH),
                .WIDTH (FlitWidth)
            ) u_fifo (
                .clk     (clk),
                .arst    (arst),
                .i_push  (w_push[v]),
                .i_data  (fin_req_i.fdata),
                .i_pop   (w_pop[v]),
                .o_data  (w_front[v]),
                .o_full  (w_full[v]),
                .o_empty (w_empty[v])
            );
        end
    endgenerate

    // Fixed-priority VC pick among non-empty FIFOs, re-evaluated every cycle
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_vc    = '0;
        if (HighPriority == ZeroLowPrior) begin
            for (int v = 0; v < NumVirtChn; v++) begin
                if (!w_empty[v]) begin
                    w_sel_valid = 1'b1;
                    w_sel_vc    = VcWidth'(v);
                end
            end
        end else begin
            for (int v = NumVirtChn - 1; v >= 0; v--) begin
                if (!w_empty[v]) begin
                    w_sel_valid = 1'b1;
                    w_sel_vc    = VcWidth'(v);
                end
            end
        end
    end

    assign w_front_flit = w_front[w_sel_vc];
    assign w_hdr        = w_front_flit[FlitWidth-1 -: HdrWidth];
    assign w_head_route = xy_route(w_hdr.x_dest, w_hdr.y_dest,
                                   ROUTER_X_ID, ROUTER_Y_ID);

    // Decide whether the selected front flit is forwarded or dropped
    always_comb begin
        w_drop      = 1'b0;
        w_req_valid = 1'b0;
        w_req_dir   = LOCAL;
        if (w_sel_valid) begin
            if (r_state[w_sel_vc] == c_IDLE) begin
                if ((w_hdr.ftype != HEAD_FLIT) ||
                    (w_head_route == s_route_dir_t'(c_IN_DIR))) begin
                    w_drop = 1'b1;
                end else begin
                    w_req_valid = 1'b1;
                    w_req_dir   = w_head_route;
                end
            end else begin
                w_req_valid = 1'b1;
                w_req_dir   = r_route[w_sel_vc];
            end
        end
    end

    assign w_out_idx = compact_dir(w_req_dir, c_IN_DIR);
    assign w_pop_any = w_drop || (w_req_valid && fout_resp_i[w_out_idx].ready);
    assign err_o     = w_drop;

    // Drive exactly one output request; every other entry stays all-zero
    always_comb begin
        fout_req_o = '0;
        if (w_req_valid) begin
            fout_req_o[w_out_idx].fdata = w_front_flit;
            fout_req_o[w_out_idx].valid = 1'b1;
            fout_req_o[w_out_idx].vc_id = w_sel_vc;
        end
    end

    // Per-VC packet state: lock the head's route until the tail leaves
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int v = 0; v < NumVirtChn; v++) begin
                r_state[v] <= c_IDLE;
                r_route[v] <= LOCAL;
            end
        end else if (w_pop_any && w_req_valid) begin
            if (r_state[w_sel_vc] == c_IDLE) begin
                if (w_hdr.pkt_size != '0) begin
                    r_state[w_sel_vc] <= c_BUSY;
                    r_route[w_sel_vc] <= w_head_route;
                end
            end else if (w_hdr.ftype == TAIL_FLIT) begin
                r_state[w_sel_vc] <= c_IDLE;
            end
        end
    end

endmodule
`default_nettype wire
